// File: rtl/mc_control_if.sv
// Bus between the multicycle controller and its datapath/memory: decoded
// instruction fields and mem_ready in, datapath control strobes and status out.
interface mc_control_if;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       mem_ready;

  logic       PCWrite;
  logic       PCWriteCond;
  logic       IorD;
  logic       MemRead;
  logic       MemWrite;
  logic       IRWrite;
  logic       MemtoReg;
  logic       ALUSrcA;
  logic       RegWrite;
  logic       RegDst;
  logic [1:0] PCSource;
  logic [1:0] ALUOp;
  logic [1:0] ALUSrcB;
  logic       mem_err;
  logic       illegal;
  logic [3:0] state_o;

  modport master (
    input  opcode, funct, mem_ready,
    output PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg,
           ALUSrcA, RegWrite, RegDst, PCSource, ALUOp, ALUSrcB,
           mem_err, illegal, state_o
  );

  modport slave (
    output opcode, funct, mem_ready,
    input  PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg,
           ALUSrcA, RegWrite, RegDst, PCSource, ALUOp, ALUSrcB,
           mem_err, illegal, state_o
  );
endinterface

// File: rtl/mc_control.sv
// Multicycle MIPS-style Moore controller with a bounded memory-wait watchdog.
// Define MC_CONTROL_ILLEGAL_TRAP_EN to trap (and flag) unknown opcodes instead of treating them as NOPs.
module mc_control #(
  parameter int MEM_WAIT_MAX = 15
) (
  input logic          clk,
  input logic          rst_n,
  mc_control_if.master bus
);

  localparam logic [3:0] FETCH  = 4'd0;
  localparam logic [3:0] DECODE = 4'd1;
  localparam logic [3:0] MEMADR = 4'd2;
  localparam logic [3:0] MEMRD  = 4'd3;
  localparam logic [3:0] MEMWB  = 4'd4;
  localparam logic [3:0] MEMWR  = 4'd5;
  localparam logic [3:0] EXEC   = 4'd6;
  localparam logic [3:0] ALUWB  = 4'd7;
  localparam logic [3:0] BRANCH = 4'd8;
  localparam logic [3:0] JUMP   = 4'd9;
  localparam logic [3:0] ADDIEX = 4'd10;
  localparam logic [3:0] ADDIWB = 4'd11;
  localparam logic [3:0] TRAP   = 4'd12;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_ADDI  = 6'h08;

  localparam int CW = ($clog2(MEM_WAIT_MAX + 1) < 4) ? 4 : $clog2(MEM_WAIT_MAX + 1);
  localparam logic [CW-1:0] WAIT_MAX = CW'(MEM_WAIT_MAX);

  logic [3:0]    state, state_next;
  logic [CW-1:0] wait_cnt, wait_cnt_next;
  logic          mem_err_q;
  logic          is_mem;
  logic          wait_expired;
  logic          funct_unused;

  // funct belongs to the ALU control block; it is carried on the bus only.
  assign funct_unused = ^bus.funct;

  // NOTE: combinational blocks use blocking '=' and assign a default to every
  // output first, so no path leaves a value held and no latch is inferred.
  always_comb begin
    is_mem        = (state == FETCH) || (state == MEMRD) || (state == MEMWR);
    wait_expired  = is_mem && !bus.mem_ready && (wait_cnt == WAIT_MAX);
    // Counter runs only while a memory state waits; any exit or completion clears it.
    wait_cnt_next = (is_mem && !bus.mem_ready && !wait_expired) ? wait_cnt + CW'(1) : '0;

    state_next = state;
    case (state)
      FETCH: begin
        if (bus.mem_ready)     state_next = DECODE;
        else if (wait_expired) state_next = TRAP;
      end
      DECODE: begin
        case (bus.opcode)
          OP_RTYPE:      state_next = EXEC;
          OP_LW, OP_SW:  state_next = MEMADR;
          OP_BEQ:        state_next = BRANCH;
          OP_J:          state_next = JUMP;
          OP_ADDI:       state_next = ADDIEX;
          default: begin
`ifdef MC_CONTROL_ILLEGAL_TRAP_EN
            state_next = TRAP;
`else
            state_next = FETCH;
`endif
          end
        endcase
      end
      MEMADR: begin
        if (bus.opcode == OP_LW)      state_next = MEMRD;
        else if (bus.opcode == OP_SW) state_next = MEMWR;
        else                          state_next = FETCH;
      end
      MEMRD: begin
        if (bus.mem_ready)     state_next = MEMWB;
        else if (wait_expired) state_next = TRAP;
      end
      MEMWR: begin
        if (bus.mem_ready)     state_next = FETCH;
        else if (wait_expired) state_next = TRAP;
      end
      EXEC:    state_next = ALUWB;
      ADDIEX:  state_next = ADDIWB;
      MEMWB, ALUWB, BRANCH, JUMP, ADDIWB: state_next = FETCH;
      TRAP:    state_next = TRAP;
      default: state_next = FETCH;
    endcase
  end

  // NOTE: sequential state uses non-blocking '<=' so every register samples
  // the pre-edge values of the others.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= FETCH;
      wait_cnt  <= '0;
      mem_err_q <= 1'b0;
    end else begin
      state    <= state_next;
      wait_cnt <= wait_cnt_next;
      if (wait_expired) mem_err_q <= 1'b1;
    end
  end

`ifdef MC_CONTROL_ILLEGAL_TRAP_EN
  logic op_known;
  logic illegal_q;

  assign op_known = (bus.opcode == OP_RTYPE) || (bus.opcode == OP_LW) ||
                    (bus.opcode == OP_SW)    || (bus.opcode == OP_BEQ) ||
                    (bus.opcode == OP_J)     || (bus.opcode == OP_ADDI);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                             illegal_q <= 1'b0;
    else if (state == DECODE && !op_known)  illegal_q <= 1'b1;
  end

  assign bus.illegal = illegal_q;
`else
  assign bus.illegal = 1'b0;
`endif

  assign bus.mem_err = mem_err_q;
  assign bus.state_o = state;

  // Pure state decode, except the fetch commit strobes, which must mark the
  // exact cycle the instruction word arrives and stay low while held in reset.
  always_comb begin
    bus.PCWrite     = 1'b0;
    bus.PCWriteCond = 1'b0;
    bus.IorD        = 1'b0;
    bus.MemRead     = 1'b0;
    bus.MemWrite    = 1'b0;
    bus.IRWrite     = 1'b0;
    bus.MemtoReg    = 1'b0;
    bus.ALUSrcA     = 1'b0;
    bus.RegWrite    = 1'b0;
    bus.RegDst      = 1'b0;
    bus.PCSource    = 2'b00;
    bus.ALUOp       = 2'b00;
    bus.ALUSrcB     = 2'b00;
    case (state)
      FETCH: begin
        bus.MemRead = 1'b1;
        bus.ALUSrcB = 2'b01;
        bus.IRWrite = bus.mem_ready && rst_n;
        bus.PCWrite = bus.mem_ready && rst_n;
      end
      DECODE:  bus.ALUSrcB = 2'b11;
      MEMADR, ADDIEX: begin
        bus.ALUSrcA = 1'b1;
        bus.ALUSrcB = 2'b10;
      end
      MEMRD: begin
        bus.MemRead = 1'b1;
        bus.IorD    = 1'b1;
      end
      MEMWB: begin
        bus.RegWrite = 1'b1;
        bus.MemtoReg = 1'b1;
      end
      MEMWR: begin
        bus.MemWrite = 1'b1;
        bus.IorD     = 1'b1;
      end
      EXEC: begin
        bus.ALUSrcA = 1'b1;
        bus.ALUOp   = 2'b10;
      end
      ALUWB: begin
        bus.RegWrite = 1'b1;
        bus.RegDst   = 1'b1;
      end
      BRANCH: begin
        bus.ALUSrcA     = 1'b1;
        bus.ALUOp       = 2'b01;
        bus.PCWriteCond = 1'b1;
        bus.PCSource    = 2'b01;
      end
      JUMP: begin
        bus.PCWrite  = 1'b1;
        bus.PCSource = 2'b10;
      end
      ADDIWB:  bus.RegWrite = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mc_control.sv
// Scoreboard bench for mc_control: expected state/control words are queued as
// each cycle's stimulus is applied and compared against the sampled outputs.
module tb_mc_control;

  localparam logic [3:0] FETCH  = 4'd0;
  localparam logic [3:0] DECODE = 4'd1;
  localparam logic [3:0] MEMADR = 4'd2;
  localparam logic [3:0] MEMRD  = 4'd3;
  localparam logic [3:0] MEMWB  = 4'd4;
  localparam logic [3:0] MEMWR  = 4'd5;
  localparam logic [3:0] EXEC   = 4'd6;
  localparam logic [3:0] ALUWB  = 4'd7;
  localparam logic [3:0] BRANCH = 4'd8;
  localparam logic [3:0] JUMP   = 4'd9;
  localparam logic [3:0] ADDIEX = 4'd10;
  localparam logic [3:0] ADDIWB = 4'd11;
  localparam logic [3:0] TRAP   = 4'd12;

  typedef struct packed {
    logic [3:0]  st;
    logic [17:0] ctrl;
  } obs_t;

  logic clk;
  logic rst_n;
  int   checks = 0;
  int   passes = 0;
  obs_t exp_q[$];
  obs_t obs_q[$];

  mc_control_if bus ();

  mc_control #(.MEM_WAIT_MAX(15)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Control word order: PCWrite PCWriteCond IorD MemRead MemWrite IRWrite
  // MemtoReg ALUSrcA RegWrite RegDst PCSource ALUOp ALUSrcB mem_err illegal
  function automatic logic [17:0] ctrl_of(input logic [3:0] st, input logic mr,
                                          input logic err, input logic ill);
    logic pcw, pcwc, iord, mrd, mwr, irw, m2r, asa, rw, rd;
    logic [1:0] pcs, aop, asb;
    {pcw, pcwc, iord, mrd, mwr, irw, m2r, asa, rw, rd} = '0;
    pcs = 2'b00; aop = 2'b00; asb = 2'b00;
    case (st)
      FETCH:  begin mrd = 1; asb = 2'b01; irw = mr; pcw = mr; end
      DECODE: asb = 2'b11;
      MEMADR: begin asa = 1; asb = 2'b10; end
      MEMRD:  begin mrd = 1; iord = 1; end
      MEMWB:  begin rw = 1; m2r = 1; end
      MEMWR:  begin mwr = 1; iord = 1; end
      EXEC:   begin asa = 1; aop = 2'b10; end
      ALUWB:  begin rw = 1; rd = 1; end
      BRANCH: begin asa = 1; aop = 2'b01; pcwc = 1; pcs = 2'b01; end
      JUMP:   begin pcw = 1; pcs = 2'b10; end
      ADDIEX: begin asa = 1; asb = 2'b10; end
      ADDIWB: rw = 1;
      default: ;
    endcase
    return {pcw, pcwc, iord, mrd, mwr, irw, m2r, asa, rw, rd, pcs, aop, asb, err, ill};
  endfunction

  function automatic obs_t sample();
    obs_t o;
    o.st   = bus.state_o;
    o.ctrl = {bus.PCWrite, bus.PCWriteCond, bus.IorD, bus.MemRead, bus.MemWrite,
              bus.IRWrite, bus.MemtoReg, bus.ALUSrcA, bus.RegWrite, bus.RegDst,
              bus.PCSource, bus.ALUOp, bus.ALUSrcB, bus.mem_err, bus.illegal};
    return o;
  endfunction

  // One clock of stimulus: queue the expectation, sample mid-cycle, return just after the edge.
  task automatic drive(input logic [3:0] st, input logic mr, input logic err, input logic ill);
    obs_t e;
    bus.mem_ready = mr;
    e.st   = st;
    e.ctrl = ctrl_of(st, mr, err, ill);
    exp_q.push_back(e);
    @(negedge clk);
    obs_q.push_back(sample());
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    bus.mem_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_reset();
    obs_t e, o;
    rst_n = 1'b0;
    bus.mem_ready = 1'b1;
    bus.opcode = 6'h00;
    bus.funct = 6'h20;
    e.st = FETCH;
    e.ctrl = ctrl_of(FETCH, 1'b0, 1'b0, 1'b0);
    exp_q.push_back(e);
    repeat (2) @(posedge clk);
    @(negedge clk);
    obs_q.push_back(sample());
    @(posedge clk);
    #1 rst_n = 1'b1;
    e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
    if (o !== e) $display("FAIL reset: got st=%0d ctrl=%05h want st=%0d ctrl=%05h", o.st, o.ctrl, e.st, e.ctrl);
    else passes++;
  endtask

  task automatic test_rtype();
    obs_t e, o;
    bus.opcode = 6'h00;
    drive(FETCH, 1, 0, 0); drive(DECODE, 1, 0, 0); drive(EXEC, 1, 0, 0);
    drive(ALUWB, 0, 0, 0); drive(FETCH, 0, 0, 0);
    for (int i = 0; exp_q.size() > 0; i++) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) $display("FAIL rtype[%0d]: got st=%0d ctrl=%05h want st=%0d ctrl=%05h", i, o.st, o.ctrl, e.st, e.ctrl);
      else passes++;
    end
  endtask

  task automatic test_load_wait();
    obs_t e, o;
    bus.opcode = 6'h23;
    drive(FETCH, 1, 0, 0); drive(DECODE, 0, 0, 0); drive(MEMADR, 1, 0, 0);
    drive(MEMRD, 0, 0, 0); drive(MEMRD, 0, 0, 0); drive(MEMRD, 0, 0, 0); drive(MEMRD, 1, 0, 0);
    drive(MEMWB, 0, 0, 0); drive(FETCH, 0, 0, 0);
    for (int i = 0; exp_q.size() > 0; i++) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) $display("FAIL load[%0d]: got st=%0d ctrl=%05h want st=%0d ctrl=%05h", i, o.st, o.ctrl, e.st, e.ctrl);
      else passes++;
    end
  endtask

  task automatic test_store_branch_jump_addi();
    obs_t e, o;
    bus.opcode = 6'h2B;
    drive(FETCH, 1, 0, 0); drive(DECODE, 0, 0, 0); drive(MEMADR, 0, 0, 0); drive(MEMWR, 1, 0, 0);
    bus.opcode = 6'h04;
    drive(FETCH, 1, 0, 0); drive(DECODE, 1, 0, 0); drive(BRANCH, 1, 0, 0);
    bus.opcode = 6'h02;
    drive(FETCH, 1, 0, 0); drive(DECODE, 0, 0, 0); drive(JUMP, 1, 0, 0);
    bus.opcode = 6'h08;
    drive(FETCH, 1, 0, 0); drive(DECODE, 0, 0, 0); drive(ADDIEX, 1, 0, 0); drive(ADDIWB, 1, 0, 0);
    drive(FETCH, 0, 0, 0);
    for (int i = 0; exp_q.size() > 0; i++) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) $display("FAIL back_to_back[%0d]: got st=%0d ctrl=%05h want st=%0d ctrl=%05h", i, o.st, o.ctrl, e.st, e.ctrl);
      else passes++;
    end
  endtask

  task automatic test_illegal();
    obs_t e, o;
    bus.opcode = 6'h3F;
    drive(FETCH, 1, 0, 0); drive(DECODE, 0, 0, 0);
`ifdef MC_CONTROL_ILLEGAL_TRAP_EN
    drive(TRAP, 1, 0, 1); drive(TRAP, 0, 0, 1);
    apply_reset();
    drive(FETCH, 0, 0, 0);
`else
    drive(FETCH, 0, 0, 0); drive(FETCH, 1, 0, 0); drive(DECODE, 0, 0, 0);
    apply_reset();
`endif
    for (int i = 0; exp_q.size() > 0; i++) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) $display("FAIL illegal[%0d]: got st=%0d ctrl=%05h want st=%0d ctrl=%05h", i, o.st, o.ctrl, e.st, e.ctrl);
      else passes++;
    end
  endtask

  task automatic test_wait_limit();
    obs_t e, o;
    apply_reset();
    bus.opcode = 6'h02;
    for (int k = 0; k < 15; k++) drive(FETCH, 0, 0, 0);
    drive(FETCH, 1, 0, 0); drive(DECODE, 0, 0, 0); drive(JUMP, 0, 0, 0); drive(FETCH, 0, 0, 0);
    for (int i = 0; exp_q.size() > 0; i++) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) $display("FAIL wait_limit[%0d]: got st=%0d ctrl=%05h want st=%0d ctrl=%05h", i, o.st, o.ctrl, e.st, e.ctrl);
      else passes++;
    end
  endtask

  task automatic test_wait_timeout();
    obs_t e, o;
    apply_reset();
    for (int k = 0; k < 16; k++) drive(FETCH, 0, 0, 0);
    drive(TRAP, 1, 1, 0); drive(TRAP, 1, 1, 0); drive(TRAP, 0, 1, 0);
    apply_reset();
    drive(FETCH, 0, 0, 0);
    for (int i = 0; exp_q.size() > 0; i++) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) $display("FAIL wait_timeout[%0d]: got st=%0d ctrl=%05h want st=%0d ctrl=%05h", i, o.st, o.ctrl, e.st, e.ctrl);
      else passes++;
    end
  endtask

  task automatic test_reset_mid_write();
    obs_t e, o;
    apply_reset();
    bus.opcode = 6'h2B;
    drive(FETCH, 1, 0, 0); drive(DECODE, 0, 0, 0); drive(MEMADR, 0, 0, 0); drive(MEMWR, 0, 0, 0);
    // Still in MEMWR here; reset drops it between clock edges.
    checks++;
    if (bus.MemWrite !== 1'b1) $display("FAIL mid_write_pre: got MemWrite=%b want 1", bus.MemWrite);
    else passes++;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.MemWrite, bus.state_o} !== {1'b0, FETCH})
      $display("FAIL mid_write_async: got MemWrite=%b st=%0d want MemWrite=0 st=%0d", bus.MemWrite, bus.state_o, FETCH);
    else passes++;
    @(posedge clk);
    #1 rst_n = 1'b1;
    bus.opcode = 6'h00;
    drive(FETCH, 1, 0, 0); drive(DECODE, 0, 0, 0);
    for (int i = 0; exp_q.size() > 0; i++) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) $display("FAIL mid_write[%0d]: got st=%0d ctrl=%05h want st=%0d ctrl=%05h", i, o.st, o.ctrl, e.st, e.ctrl);
      else passes++;
    end
  endtask

  initial begin
    rst_n = 1'b0;
    bus.mem_ready = 1'b0;
    bus.opcode = 6'h00;
    bus.funct = 6'h00;
    test_reset();
    test_rtype();
    test_load_wait();
    test_store_branch_jump_addi();
    test_illegal();
    test_wait_limit();
    test_wait_timeout();
    test_reset_mid_write();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
